acumulador_ventana: RTL

- Parametrised successor of the team's 4-bit feedback accumulator.
- Sums unsigned input samples into a configurable-width register.
- Selectable wrap or saturate mode; per-sample carry flag plus sticky overflow flag.
- Optional fixed-length window: after N valid samples it latches the total, pulses done and restarts. Sits between a sample source and a downstream averaging/reporting stage.

---
 rtl/acumulador_ventana_pkg.sv | 16 +
 rtl/acumulador_ventana_contador.sv | 35 +++
 rtl/acumulador_ventana.sv | 100 ++++++++++
 3 files changed

// File: rtl/acumulador_ventana_pkg.sv
// Shared definitions for the windowed accumulator: mode encodings and the
// window-counter width rule.
package acumulador_ventana_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // A free-running accumulator (window 0) still exposes a 1-bit count port.
    function automatic int cnt_width(input int window);
        if (window == 0) begin
            return 1;
        end
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/acumulador_ventana_contador.sv
// Window sample counter: tracks accepted samples and flags the terminal one.
module contador_ventana
    import acumulador_ventana_pkg::*;
#(
    parameter int WINDOW = 0,
    parameter int CNT_W  = cnt_width(WINDOW)
) (
    input  logic             clock,
    input  logic             i_rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             term
);

    localparam logic [CNT_W-1:0] LAST   = CNT_W'(WINDOW - 1);
    localparam logic             WIN_EN = (WINDOW != 0);

    logic [CNT_W-1:0] count_q;

    // term is combinational so the top can latch the total on the same edge
    assign term  = WIN_EN && inc && !clear && (count_q == LAST);
    assign count = count_q;

    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else if (clear || term) begin
            count_q <= '0;
        end else if (inc && WIN_EN) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/acumulador_ventana.sv
// Unsigned sample accumulator with wrap/saturate modes, carry flags and an
// optional fixed-length window that latches the total and restarts.
module acumulador_ventana
    import acumulador_ventana_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int ACC_W       = 6,
    parameter int WINDOW      = 0,
    parameter int SAT_DEFAULT = 0
) (
    input  logic                         clock,
    input  logic                         i_rst_n,
    input  logic [DATA_W-1:0]            i_entrada,
    input  logic                         i_valid,
    input  logic                         i_clear,
    input  logic                         i_sat_en,
    output logic [ACC_W-1:0]             o_data,
    output logic                         o_overflow,
    output logic                         o_ovf_sticky,
    output logic [ACC_W-1:0]             o_result,
    output logic                         o_done,
    output logic [cnt_width(WINDOW)-1:0] o_count
);

    localparam int CNT_W = cnt_width(WINDOW);
    localparam int SUM_W = ACC_W + 1;

    generate
        if (DATA_W < 1 || ACC_W < DATA_W || WINDOW < 0 || SAT_DEFAULT < 0 || SAT_DEFAULT > 1) begin : g_bad_params
            $error("acumulador_ventana: illegal parameter combination");
        end
    endgenerate

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] result_q;
    logic             ovf_q;
    logic             sticky_q;
    logic             done_q;

    logic [SUM_W-1:0] sum;
    logic             carry;
    logic [ACC_W-1:0] acc_next;
    logic             accept;
    logic             term;

    assign sum      = {1'b0, acc_q} + SUM_W'(i_entrada);
    assign carry    = sum[ACC_W];
    assign acc_next = ((i_sat_en == MODE_SAT) && carry) ? '1 : sum[ACC_W-1:0];
    assign accept   = i_valid && !i_clear;

    contador_ventana #(
        .WINDOW (WINDOW),
        .CNT_W  (CNT_W)
    ) u_contador (
        .clock   (clock),
        .i_rst_n (i_rst_n),
        .clear   (i_clear),
        .inc     (accept),
        .count   (o_count),
        .term    (term)
    );

    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (i_clear) begin
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (i_valid) begin
            ovf_q <= carry;
            if (term) begin
                // terminal sample: total goes out, running state restarts
                result_q <= acc_next;
                done_q   <= 1'b1;
                acc_q    <= '0;
                sticky_q <= 1'b0;
            end else begin
                acc_q    <= acc_next;
                sticky_q <= sticky_q | carry;
                done_q   <= 1'b0;
            end
        end else begin
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end
    end

    assign o_data       = acc_q;
    assign o_overflow   = ovf_q;
    assign o_ovf_sticky = sticky_q;
    assign o_result     = result_q;
    assign o_done       = done_q;

endmodule
